// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------
// | fifo_pkg : default sizing constants and types for the synchronous FIFO
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

  typedef logic [FIFO_DATA_W-1:0] fifo_data_t;
  typedef logic [FIFO_ADDR_W-1:0] fifo_addr_t;
  typedef logic [FIFO_CNT_W-1:0]  fifo_cnt_t;

endpackage

`default_nettype wire

// File: rtl/fifo_dpram.sv
// +----------------------------------------------------------------------------
// | fifo_dpram : simple dual-port RAM, one write port, one registered read port
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module fifo_dpram
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_W,
  parameter  int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_buffer.sv
// +----------------------------------------------------------------------------
// | fifo_buffer : synchronous FIFO with count, full/empty/almost flags, rd_valid
// | Optional sticky overflow/underflow flags with macro FIFO_ERR_FLAGS_EN.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module fifo_buffer
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_W,
  parameter  int DEPTH      = FIFO_DEPTH,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  has_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok & rst_n),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok & rst_n),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset, so data_out reads zero until the first pop.
  assign data_out = has_data ? ram_rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_valid     <= 1'b0;
      has_data     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        has_data <= 1'b1;
      end
      rd_valid     <= pop_ok;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_W'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
      almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_set;
  logic underflow_set;

  assign overflow_set  = push & full & ~pop_ok;
  assign underflow_set = pop & empty;

  // Sticky; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

`default_nettype wire
